load_store_unit: RTL and testbench

Data-memory responder for the decode/control stage. It consumes the per-instruction memory request (write enable, size select, unsigned flag, address, store data), drives a 32-bit byte-lane memory bus with a valid/ready handshake and returns aligned, extended load data. It stalls the core until the access completes. Misaligned accesses are split into two word-aligned bus beats.

---
 rtl/load_store_unit.sv | 302 ++++++++++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: data-memory responder between the decode/control stage and a 32-bit
// byte-lane memory bus with a valid/ready handshake.
//
// A request (load or store) is accepted in IDLE. The access goes out as one word-aligned
// bus beat, or two beats when it crosses a word boundary. Load results come back
// lane-aligned and zero/sign extended. The core is stalled until the access completes.
//
// Parameters:
//   TIMEOUT_CYCLES - bus-wait cycles per beat before the access is aborted (0 = never)
//   SIZE_W         - width of req_size
//
// Ports:
//   clock, reset             - core clock, asynchronous active-high reset
//   req_valid/write/size/unsigned/addr/wdata - per-instruction memory request
//   stall                    - hold PC/pipeline while the access is in flight
//   load_valid, load_data    - one-cycle pulse with the extended load result (data held)
//   err                      - one-cycle pulse when a beat times out
//   misalign                 - only with LSU_MISALIGN_TRAP_EN: one-cycle pulse on a trapped
//                              misaligned request
//   bus_valid/ready/addr/we/be/wdata/rdata - memory bus beat interface
//
// Optional feature: define LSU_MISALIGN_TRAP_EN to trap misaligned requests instead of
// splitting them into two beats.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned SIZE_W         = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [SIZE_W-1:0] req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              stall,
  output logic              load_valid,
  output logic [31:0]       load_data,
  output logic              err,
`ifdef LSU_MISALIGN_TRAP_EN
  output logic              misalign,
`endif
  output logic              bus_valid,
  input  logic              bus_ready,
  output logic [31:0]       bus_addr,
  output logic              bus_we,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic [31:0]       bus_rdata
);

  typedef enum logic [1:0] {StIdle, StBeat1, StBeat2, StDone} state_e;

  // Decoded size: 0 = byte, 1 = half, 2 = word
  localparam logic [1:0] SzByte = 2'd0;
  localparam logic [1:0] SzHalf = 2'd1;

  state_e      state_q, state_d;
  logic        valid_q, valid_d;
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be2_q, be2_d;
  logic [31:0] wdata2_q, wdata2_d;
  logic        split_q, split_d;
  logic [1:0]  off_q, off_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic        write_q, write_d;
  logic [31:0] rdata1_q, rdata1_d;
  logic [31:0] cnt_q, cnt_d;
  logic        load_valid_q, load_valid_d;
  logic [31:0] load_data_q, load_data_d;
  logic        err_q, err_d;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        misalign_q, misalign_d;
`endif

  // Request decode
  logic [1:0]  req_sz;
  logic [3:0]  base_mask;
  logic [6:0]  mask7;
  logic        req_split;
  logic [63:0] wdata_sh;

  always_comb begin
    req_sz = 2'd2;
    if (req_size == '0) begin
      req_sz = SzByte;
    end else if (req_size == SIZE_W'(1)) begin
      req_sz = SzHalf;
    end
    case (req_sz)
      SzByte:  base_mask = 4'b0001;
      SzHalf:  base_mask = 4'b0011;
      default: base_mask = 4'b1111;
    endcase
    mask7     = {3'b000, base_mask} << req_addr[1:0];
    req_split = |mask7[6:4];
    // Low half feeds beat 1, high half feeds beat 2 of a split store
    wdata_sh  = {32'h0, req_wdata} << {req_addr[1:0], 3'b000};
  end

  // Load result from the final beat: beat 1 word alone, or beat 2 word above beat 1 word
  logic [31:0] fin_win;
  logic [31:0] ld_ext;

  always_comb begin
    if (state_q == StBeat2) begin
      fin_win = 32'({bus_rdata, rdata1_q} >> {off_q, 3'b000});
    end else begin
      fin_win = 32'({32'h0, bus_rdata} >> {off_q, 3'b000});
    end
    case (size_q)
      SzByte:  ld_ext = {{24{fin_win[7] & ~uns_q}}, fin_win[7:0]};
      SzHalf:  ld_ext = {{16{fin_win[15] & ~uns_q}}, fin_win[15:0]};
      default: ld_ext = fin_win;
    endcase
  end

  logic waiting;

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    we_d         = we_q;
    be_d         = be_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be2_d        = be2_q;
    wdata2_d     = wdata2_q;
    split_d      = split_q;
    off_d        = off_q;
    size_d       = size_q;
    uns_d        = uns_q;
    write_d      = write_q;
    rdata1_d     = rdata1_q;
    cnt_d        = cnt_q;
    load_valid_d = 1'b0;
    load_data_d  = load_data_q;
    err_d        = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    misalign_d   = 1'b0;
`endif
    waiting      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          off_d    = req_addr[1:0];
          size_d   = req_sz;
          uns_d    = req_unsigned;
          write_d  = req_write;
          split_d  = req_split;
          be2_d    = {1'b0, mask7[6:4]};
          wdata2_d = wdata_sh[63:32];
          cnt_d    = '0;
`ifdef LSU_MISALIGN_TRAP_EN
          if (req_split) begin
            misalign_d = 1'b1;
            state_d    = StDone;
          end else begin
`endif
            valid_d = 1'b1;
            addr_d  = {req_addr[31:2], 2'b00};
            be_d    = mask7[3:0];
            wdata_d = wdata_sh[31:0];
            we_d    = req_write;
            state_d = StBeat1;
`ifdef LSU_MISALIGN_TRAP_EN
          end
`endif
        end
      end

      StBeat1: begin
        if (bus_ready) begin
          if (split_q) begin
            rdata1_d = bus_rdata;
            addr_d   = addr_q + 32'd4;  // wraps past 0xFFFF_FFFC
            be_d     = be2_q;
            wdata_d  = wdata2_q;
            cnt_d    = '0;
            state_d  = StBeat2;
          end else begin
            valid_d = 1'b0;
            we_d    = 1'b0;
            be_d    = 4'h0;
            state_d = StDone;
            if (!write_q) begin
              load_valid_d = 1'b1;
              load_data_d  = ld_ext;
            end
          end
        end else begin
          waiting = 1'b1;
        end
      end

      StBeat2: begin
        if (bus_ready) begin
          valid_d = 1'b0;
          we_d    = 1'b0;
          be_d    = 4'h0;
          state_d = StDone;
          if (!write_q) begin
            load_valid_d = 1'b1;
            load_data_d  = ld_ext;
          end
        end else begin
          waiting = 1'b1;
        end
      end

      StDone: begin
        // A request seen here is the stale instruction that just completed
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase

    // Per-beat wait budget; an abort leaves any already-written first beat in place
    if (waiting) begin
      if (TIMEOUT_CYCLES != 0 && cnt_q == TIMEOUT_CYCLES - 1) begin
        valid_d     = 1'b0;
        we_d        = 1'b0;
        be_d        = 4'h0;
        err_d       = 1'b1;
        load_data_d = '0;
        state_d     = StDone;
      end else begin
        cnt_d = cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      valid_q      <= 1'b0;
      we_q         <= 1'b0;
      be_q         <= 4'h0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be2_q        <= 4'h0;
      wdata2_q     <= '0;
      split_q      <= 1'b0;
      off_q        <= 2'd0;
      size_q       <= 2'd0;
      uns_q        <= 1'b0;
      write_q      <= 1'b0;
      rdata1_q     <= '0;
      cnt_q        <= '0;
      load_valid_q <= 1'b0;
      load_data_q  <= '0;
      err_q        <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      misalign_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      we_q         <= we_d;
      be_q         <= be_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be2_q        <= be2_d;
      wdata2_q     <= wdata2_d;
      split_q      <= split_d;
      off_q        <= off_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      write_q      <= write_d;
      rdata1_q     <= rdata1_d;
      cnt_q        <= cnt_d;
      load_valid_q <= load_valid_d;
      load_data_q  <= load_data_d;
      err_q        <= err_d;
`ifdef LSU_MISALIGN_TRAP_EN
      misalign_q   <= misalign_d;
`endif
    end
  end

  // Stall is combinational in IDLE so the core holds on the request cycle itself
  assign stall      = (state_q == StIdle && req_valid) || state_q == StBeat1 ||
                      state_q == StBeat2;
  assign load_valid = load_valid_q;
  assign load_data  = load_data_q;
  assign err        = err_q;
`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign   = misalign_q;
`endif
  assign bus_valid  = valid_q;
  assign bus_addr   = addr_q;
  assign bus_we     = we_q;
  assign bus_be     = be_q;
  assign bus_wdata  = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a load-result scoreboard.
module tb_load_store_unit;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        load_valid;
  logic [31:0] load_data;
  logic        err;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        misalign;
`endif
  logic        bus_valid;
  logic        bus_ready;
  logic [31:0] bus_addr;
  logic        bus_we;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;

  int passed = 0;
  int failed = 0;
  int total  = 0;
  logic [31:0] sb[$];

  load_store_unit #(
    .TIMEOUT_CYCLES(4),
    .SIZE_W        (2)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_write   (req_write),
    .req_size    (req_size),
    .req_unsigned(req_unsigned),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .stall       (stall),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .err         (err),
`ifdef LSU_MISALIGN_TRAP_EN
    .misalign    (misalign),
`endif
    .bus_valid   (bus_valid),
    .bus_ready   (bus_ready),
    .bus_addr    (bus_addr),
    .bus_we      (bus_we),
    .bus_be      (bus_be),
    .bus_wdata   (bus_wdata),
    .bus_rdata   (bus_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one request for the IDLE cycle, then drop req_valid; returns in BEAT1
  task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] d);
    req_write    = w;
    req_size     = sz;
    req_unsigned = u;
    req_addr     = a;
    req_wdata    = d;
    req_valid    = 1'b1;
    #1;
    check("req_stall", {31'h0, stall}, 32'h1);
    @(negedge clock);
    req_valid = 1'b0;
  endtask

  // Wait up to budget cycles for load_valid, then compare against the scoreboard head
  task automatic expect_load(input string tag, input int budget);
    int i = 0;
    logic [31:0] exp;
    while (load_valid !== 1'b1 && i < budget) begin
      @(negedge clock);
      i++;
    end
    if (load_valid === 1'b1 && sb.size() > 0) begin
      exp = sb.pop_front();
      check(tag, load_data, exp);
    end else begin
      total++;
      failed++;
      $error("FAIL %s: load_valid=%b within %0d cycles, %0d expected entries", tag,
             load_valid, budget, sb.size());
    end
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; bus_ready = 1'b0; bus_rdata = '0;
    @(negedge clock);
    check("rst_bus_valid", {31'h0, bus_valid}, 32'h0);
    check("rst_stall", {31'h0, stall}, 32'h0);
    check("rst_load_valid", {31'h0, load_valid}, 32'h0);
    check("rst_load_data", load_data, 32'h0);
    check("rst_bus_addr", bus_addr, 32'h0);
    check("rst_bus_be", {28'h0, bus_be}, 32'h0);
    check("rst_err", {31'h0, err}, 32'h0);
    reset = 1'b0;
    @(negedge clock);

    // Aligned word load, ready held high: load_valid two cycles after req_valid
    bus_ready = 1'b1; bus_rdata = 32'hDEADBEEF;
    sb.push_back(32'hDEADBEEF);
    issue(1'b0, 2'd3, 1'b0, 32'h100, 32'h0);
    check("lw_valid", {31'h0, bus_valid}, 32'h1);
    check("lw_addr", bus_addr, 32'h100);
    check("lw_be", {28'h0, bus_be}, 32'hF);
    check("lw_we", {31'h0, bus_we}, 32'h0);
    @(negedge clock);
    expect_load("lw_data", 0);
    check("lw_stall_done", {31'h0, stall}, 32'h0);
    @(negedge clock);
    check("lw_pulse", {31'h0, load_valid}, 32'h0);

    // Byte load from top lane, signed then unsigned
    bus_rdata = 32'h80123456;
    sb.push_back(32'hFFFFFF80);
    issue(1'b0, 2'd0, 1'b0, 32'h203, 32'h0);
    check("lb_addr", bus_addr, 32'h200);
    check("lb_be", {28'h0, bus_be}, 32'h8);
    @(negedge clock);
    expect_load("lb_signed", 0);
    @(negedge clock);
    sb.push_back(32'h00000080);
    issue(1'b0, 2'd0, 1'b1, 32'h203, 32'h0);
    @(negedge clock);
    expect_load("lbu", 0);
    @(negedge clock);

    // Split word store with a wait cycle on beat 1
    bus_ready = 1'b0;
    issue(1'b1, 2'd3, 1'b0, 32'h102, 32'h11223344);
    check("sw_b1_addr", bus_addr, 32'h100);
    check("sw_b1_be", {28'h0, bus_be}, 32'hC);
    check("sw_b1_wdata", bus_wdata, 32'h33440000);
    check("sw_b1_we", {31'h0, bus_we}, 32'h1);
    @(negedge clock);
    check("sw_hold_valid", {31'h0, bus_valid}, 32'h1);
    check("sw_hold_addr", bus_addr, 32'h100);
    check("sw_hold_wdata", bus_wdata, 32'h33440000);
    bus_ready = 1'b1;
    @(negedge clock);
    check("sw_b2_addr", bus_addr, 32'h104);
    check("sw_b2_be", {28'h0, bus_be}, 32'h3);
    check("sw_b2_wdata", bus_wdata, 32'h00001122);
    check("sw_b2_stall", {31'h0, stall}, 32'h1);
    @(negedge clock);
    check("sw_no_load_valid", {31'h0, load_valid}, 32'h0);
    check("sw_load_data_held", load_data, 32'h00000080);
    check("sw_done_valid", {31'h0, bus_valid}, 32'h0);
    check("sw_done_stall", {31'h0, stall}, 32'h0);
    @(negedge clock);

    // Split unsigned half load across a word boundary
    bus_rdata = 32'hAB000000;
    sb.push_back(32'h0000CDAB);
    issue(1'b0, 2'd1, 1'b1, 32'h007, 32'h0);
    check("lhu_b1_addr", bus_addr, 32'h004);
    check("lhu_b1_be", {28'h0, bus_be}, 32'h8);
    @(negedge clock);
    check("lhu_b2_addr", bus_addr, 32'h008);
    check("lhu_b2_be", {28'h0, bus_be}, 32'h1);
    bus_rdata = 32'h000000CD;
    @(negedge clock);
    expect_load("lhu_split", 0);
    @(negedge clock);

    // Split word load wrapping the address space
    bus_rdata = 32'hAABBCCDD;
    sb.push_back(32'h3344AABB);
    issue(1'b0, 2'd3, 1'b0, 32'hFFFFFFFE, 32'h0);
    check("wrap_b1_addr", bus_addr, 32'hFFFFFFFC);
    check("wrap_b1_be", {28'h0, bus_be}, 32'hC);
    @(negedge clock);
    check("wrap_b2_addr", bus_addr, 32'h00000000);
    check("wrap_b2_be", {28'h0, bus_be}, 32'h3);
    bus_rdata = 32'h11223344;
    @(negedge clock);
    expect_load("wrap_data", 0);
    @(negedge clock);

    // Timeout with size 2 (treated as word), bus never ready
    bus_ready = 1'b0;
    issue(1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
    check("sz2_be", {28'h0, bus_be}, 32'hF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("to_still_valid", {31'h0, bus_valid}, 32'h1);
    end
    @(negedge clock);
    check("to_err", {31'h0, err}, 32'h1);
    check("to_valid_drop", {31'h0, bus_valid}, 32'h0);
    check("to_stall", {31'h0, stall}, 32'h0);
    check("to_no_load_valid", {31'h0, load_valid}, 32'h0);
    check("to_load_data", load_data, 32'h0);
    @(negedge clock);
    check("to_err_pulse", {31'h0, err}, 32'h0);

    // Reset during beat 2 of a split load
    bus_ready = 1'b1; bus_rdata = 32'h80000000;
    issue(1'b0, 2'd1, 1'b0, 32'h007, 32'h0);
    @(negedge clock);
    check("rst2_in_beat2", {31'h0, bus_valid}, 32'h1);
    #2 reset = 1'b1;
    #1;
    check("rst2_valid_drop", {31'h0, bus_valid}, 32'h0);
    check("rst2_stall", {31'h0, stall}, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("rst2_no_load_valid", {31'h0, load_valid}, 32'h0);
    end

    check("sb_empty", sb.size(), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
